// File: rtl/nf10_pbs_rr_arbiter_if.sv
// PBS bus bundle: flattened per-source request/write side plus the merged port to the bridge.
interface nf10_pbs_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 64,
  parameter int CW = 8
);
  logic [N-1:0]    S_PBS_REQ;
  logic [N*DW-1:0] S_PBS_DATA;
  logic [N*CW-1:0] S_PBS_CTRL;
  logic [N-1:0]    S_PBS_WR;
  logic [N-1:0]    S_PBS_RDY;
  logic [DW-1:0]   M_PBS_DATA;
  logic [CW-1:0]   M_PBS_CTRL;
  logic            M_PBS_WR;
  logic            M_PBS_RDY;

  modport slave (
    input  S_PBS_REQ, S_PBS_DATA, S_PBS_CTRL, S_PBS_WR, M_PBS_RDY,
    output S_PBS_RDY, M_PBS_DATA, M_PBS_CTRL, M_PBS_WR
  );

  modport master (
    output S_PBS_REQ, S_PBS_DATA, S_PBS_CTRL, S_PBS_WR, M_PBS_RDY,
    input  S_PBS_RDY, M_PBS_DATA, M_PBS_CTRL, M_PBS_WR
  );
endinterface

// File: rtl/nf10_pbs_rr_arbiter.sv
// Packet-granular round-robin arbiter merging N PBS sources into one registered PBS port.
// Optional framing checker enabled by defining PBS_ARB_PROTO_CHK_EN.
//
// state | meaning
// IDLE  | no grant; all source RDY low; picks next requester after last_grant
// BUSY  | source GRANT_ID owns the port until its EOP word is accepted
module nf10_pbs_rr_arbiter #(
  parameter int C_NUM_INPUTS     = 4,
  parameter int C_PBS_DATA_WIDTH = 64,
  parameter int C_PBS_CTRL_WIDTH = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  nf10_pbs_rr_arbiter_if.slave    pbs,
  output logic [2:0]              GRANT_ID,
  output logic [C_NUM_INPUTS-1:0] PROTO_ERR
);
  localparam int N  = C_NUM_INPUTS;
  localparam int DW = C_PBS_DATA_WIDTH;
  localparam int CW = C_PBS_CTRL_WIDTH;
  localparam logic [CW-1:0] CTRL_HDR = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [2:0]    last_grant, grant_next;
  logic          found, start, accept, is_eop, g_wr;
  logic [DW-1:0] g_data;
  logic [CW-1:0] g_ctrl;

  always_comb begin
    g_data = '0;
    g_ctrl = '0;
    g_wr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (GRANT_ID == 3'(i)) begin
        g_data = pbs.S_PBS_DATA[i*DW +: DW];
        g_ctrl = pbs.S_PBS_CTRL[i*CW +: CW];
        g_wr   = pbs.S_PBS_WR[i];
      end
    end
  end

  // First pass looks above last_grant, second pass wraps to the lowest requester.
  always_comb begin
    grant_next = last_grant;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && pbs.S_PBS_REQ[i] && (3'(i) > last_grant)) begin
        found      = 1'b1;
        grant_next = 3'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && pbs.S_PBS_REQ[i]) begin
        found      = 1'b1;
        grant_next = 3'(i);
      end
    end
  end

  assign is_eop = (g_ctrl != '0) && (g_ctrl != CTRL_HDR);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    start         = 1'b0;
    accept        = 1'b0;
    pbs.S_PBS_RDY = '0;
    case (state)
      IDLE: begin
        if (|pbs.S_PBS_REQ) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < N; i++)
          pbs.S_PBS_RDY[i] = (GRANT_ID == 3'(i)) && pbs.M_PBS_RDY;
        accept = g_wr && pbs.M_PBS_RDY;
        if (accept && is_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_grant     <= 3'(N-1);
      GRANT_ID       <= '0;
      pbs.M_PBS_WR   <= 1'b0;
      pbs.M_PBS_DATA <= '0;
      pbs.M_PBS_CTRL <= '0;
    end else begin
      pbs.M_PBS_WR <= accept;
      if (accept) begin
        pbs.M_PBS_DATA <= g_data;
        pbs.M_PBS_CTRL <= g_ctrl;
      end
      if (start) GRANT_ID <= grant_next;
      if (accept && is_eop) last_grant <= GRANT_ID;
    end
  end

`ifdef PBS_ARB_PROTO_CHK_EN
  logic first_word;

  // Header must be the first word of a grant and only the first word.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      first_word <= 1'b0;
      PROTO_ERR  <= '0;
    end else begin
      if (start)       first_word <= 1'b1;
      else if (accept) first_word <= 1'b0;
      if (accept && (first_word ? (g_ctrl != CTRL_HDR) : (g_ctrl == CTRL_HDR))) begin
        for (int i = 0; i < N; i++)
          if (GRANT_ID == 3'(i)) PROTO_ERR[i] <= 1'b1;
      end
    end
  end
`else
  assign PROTO_ERR = '0;
`endif
endmodule

// File: tb/tb_nf10_pbs_rr_arbiter.sv
// Directed, table-driven bench for nf10_pbs_rr_arbiter; inputs change on the falling edge.
module tb_nf10_pbs_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 8;
`ifdef PBS_ARB_PROTO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b1;
  logic [2:0]   GRANT_ID;
  logic [N-1:0] PROTO_ERR;

  nf10_pbs_rr_arbiter_if #(.N(N), .DW(DW), .CW(CW)) pbs ();

  nf10_pbs_rr_arbiter #(
    .C_NUM_INPUTS(N), .C_PBS_DATA_WIDTH(DW), .C_PBS_CTRL_WIDTH(CW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .pbs(pbs), .GRANT_ID(GRANT_ID), .PROTO_ERR(PROTO_ERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit         rst;
    logic [3:0] req, wr;
    logic [7:0] ctrl, tag;
    logic       mrdy;
    logic [3:0] e_rdy;
    logic       e_wr;
    logic [7:0] e_src, e_ctrl, e_tag;
    logic [2:0] e_gid;
    logic [3:0] e_perr;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(bit rst, logic [3:0] req, logic [3:0] wr, logic [7:0] ctrl,
                              logic [7:0] tag, logic mrdy, logic [3:0] e_rdy, logic e_wr,
                              logic [7:0] e_src, logic [7:0] e_ctrl, logic [7:0] e_tag,
                              logic [2:0] e_gid, logic [3:0] e_perr);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.ctrl = ctrl; v.tag = tag; v.mrdy = mrdy;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_src = e_src; v.e_ctrl = e_ctrl; v.e_tag = e_tag;
    v.e_gid = e_gid; v.e_perr = e_perr;
    vq.push_back(v);
  endfunction

  // Source i always presents {i, 0, ctrl, tag} so the merged word identifies its origin.
  task automatic drive(logic [3:0] req, logic [3:0] wr, logic [7:0] ctrl, logic [7:0] tag,
                       logic mrdy);
    pbs.S_PBS_REQ = req;
    pbs.S_PBS_WR  = wr;
    pbs.M_PBS_RDY = mrdy;
    for (int i = 0; i < N; i++) begin
      pbs.S_PBS_DATA[i*DW +: DW] = {8'(i), 40'h0, ctrl, tag};
      pbs.S_PBS_CTRL[i*CW +: CW] = ctrl;
    end
  endtask

  initial begin
    logic [83:0] act, exp;
    vec_t v;

    // packet of 16 words from source 0, then a 2-word packet re-granted to source 0
    add(0, 4'h1, 4'h0, 8'h00, 8'd0, 1, 4'h0, 0, 8'd0, 8'h00, 8'd0, 3'd0, 4'h0);
    add(0, 4'h1, 4'h1, 8'hFF, 8'd1, 1, 4'h1, 0, 8'd0, 8'h00, 8'd0, 3'd0, 4'h0);
    for (int k = 2; k <= 15; k++)
      add(0, 4'h0, 4'h1, 8'h00, 8'(k), 1, 4'h1, 1, 8'd0, (k == 2) ? 8'hFF : 8'h00,
          8'(k-1), 3'd0, 4'h0);
    add(0, 4'h0, 4'h1, 8'h01, 8'd16, 1, 4'h1, 1, 8'd0, 8'h00, 8'd15, 3'd0, 4'h0);
    add(0, 4'h1, 4'h0, 8'h00, 8'd17, 1, 4'h0, 1, 8'd0, 8'h01, 8'd16, 3'd0, 4'h0);
    add(0, 4'h1, 4'h1, 8'hFF, 8'd18, 1, 4'h1, 0, 8'd0, 8'h01, 8'd16, 3'd0, 4'h0);
    add(0, 4'h0, 4'h1, 8'h01, 8'd19, 1, 4'h1, 1, 8'd0, 8'hFF, 8'd18, 3'd0, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd20, 1, 4'h0, 1, 8'd0, 8'h01, 8'd19, 3'd0, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd21, 1, 4'h0, 0, 8'd0, 8'h01, 8'd19, 3'd0, 4'h0);
    // reset, then all four requesting: grants 0,1,2,3,0; stray WR from source 1 dropped
    add(1, 4'hF, 4'h0, 8'h00, 8'd30, 1, 4'h0, 0, 8'd0, 8'h00, 8'd0,  3'd0, 4'h0);
    add(0, 4'hF, 4'h0, 8'h00, 8'd31, 1, 4'h0, 0, 8'd0, 8'h00, 8'd0,  3'd0, 4'h0);
    add(0, 4'hF, 4'h1, 8'hFF, 8'd32, 1, 4'h1, 0, 8'd0, 8'h00, 8'd0,  3'd0, 4'h0);
    add(0, 4'hF, 4'h3, 8'h01, 8'd33, 1, 4'h1, 1, 8'd0, 8'hFF, 8'd32, 3'd0, 4'h0);
    add(0, 4'hF, 4'h0, 8'h00, 8'd34, 1, 4'h0, 1, 8'd0, 8'h01, 8'd33, 3'd0, 4'h0);
    add(0, 4'hF, 4'h2, 8'hFF, 8'd35, 1, 4'h2, 0, 8'd0, 8'h01, 8'd33, 3'd1, 4'h0);
    add(0, 4'hF, 4'h2, 8'h01, 8'd36, 1, 4'h2, 1, 8'd1, 8'hFF, 8'd35, 3'd1, 4'h0);
    add(0, 4'hF, 4'h0, 8'h00, 8'd37, 1, 4'h0, 1, 8'd1, 8'h01, 8'd36, 3'd1, 4'h0);
    add(0, 4'hF, 4'h4, 8'hFF, 8'd38, 1, 4'h4, 0, 8'd1, 8'h01, 8'd36, 3'd2, 4'h0);
    add(0, 4'hF, 4'h4, 8'h01, 8'd39, 1, 4'h4, 1, 8'd2, 8'hFF, 8'd38, 3'd2, 4'h0);
    add(0, 4'hF, 4'h0, 8'h00, 8'd40, 1, 4'h0, 1, 8'd2, 8'h01, 8'd39, 3'd2, 4'h0);
    add(0, 4'hF, 4'h8, 8'hFF, 8'd41, 1, 4'h8, 0, 8'd2, 8'h01, 8'd39, 3'd3, 4'h0);
    add(0, 4'hF, 4'h8, 8'h01, 8'd42, 1, 4'h8, 1, 8'd3, 8'hFF, 8'd41, 3'd3, 4'h0);
    add(0, 4'hF, 4'h0, 8'h00, 8'd43, 1, 4'h0, 1, 8'd3, 8'h01, 8'd42, 3'd3, 4'h0);
    add(0, 4'hF, 4'h1, 8'hFF, 8'd44, 1, 4'h1, 0, 8'd3, 8'h01, 8'd42, 3'd0, 4'h0);
    add(0, 4'hF, 4'h1, 8'h01, 8'd45, 1, 4'h1, 1, 8'd0, 8'hFF, 8'd44, 3'd0, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd46, 1, 4'h0, 1, 8'd0, 8'h01, 8'd45, 3'd0, 4'h0);
    // source 1 with M_PBS_RDY toggling; WR while RDY=0 must be dropped
    add(0, 4'h2, 4'h0, 8'h00, 8'd50, 1, 4'h0, 0, 8'd0, 8'h01, 8'd45, 3'd0, 4'h0);
    add(0, 4'h2, 4'h2, 8'hFF, 8'd51, 1, 4'h2, 0, 8'd0, 8'h01, 8'd45, 3'd1, 4'h0);
    add(0, 4'h0, 4'h2, 8'h00, 8'd52, 0, 4'h0, 1, 8'd1, 8'hFF, 8'd51, 3'd1, 4'h0);
    add(0, 4'h0, 4'h2, 8'h00, 8'd53, 1, 4'h2, 0, 8'd1, 8'hFF, 8'd51, 3'd1, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd54, 0, 4'h0, 1, 8'd1, 8'h00, 8'd53, 3'd1, 4'h0);
    add(0, 4'h0, 4'h2, 8'h00, 8'd55, 1, 4'h2, 0, 8'd1, 8'h00, 8'd53, 3'd1, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd56, 0, 4'h0, 1, 8'd1, 8'h00, 8'd55, 3'd1, 4'h0);
    add(0, 4'h0, 4'h2, 8'h02, 8'd57, 1, 4'h2, 0, 8'd1, 8'h00, 8'd55, 3'd1, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd58, 1, 4'h0, 1, 8'd1, 8'h02, 8'd57, 3'd1, 4'h0);
    // source 2 drops REQ mid-packet while source 1 requests; grant held, then wraps to 1
    add(0, 4'h4, 4'h0, 8'h00, 8'd60, 1, 4'h0, 0, 8'd1, 8'h02, 8'd57, 3'd1, 4'h0);
    add(0, 4'h4, 4'h4, 8'hFF, 8'd61, 1, 4'h4, 0, 8'd1, 8'h02, 8'd57, 3'd2, 4'h0);
    add(0, 4'h2, 4'h4, 8'h00, 8'd62, 1, 4'h4, 1, 8'd2, 8'hFF, 8'd61, 3'd2, 4'h0);
    add(0, 4'h2, 4'h4, 8'h00, 8'd63, 1, 4'h4, 1, 8'd2, 8'h00, 8'd62, 3'd2, 4'h0);
    add(0, 4'h2, 4'h4, 8'h05, 8'd64, 1, 4'h4, 1, 8'd2, 8'h00, 8'd63, 3'd2, 4'h0);
    add(0, 4'h2, 4'h0, 8'h00, 8'd65, 1, 4'h0, 1, 8'd2, 8'h05, 8'd64, 3'd2, 4'h0);
    add(0, 4'h2, 4'h2, 8'hFF, 8'd66, 1, 4'h2, 0, 8'd2, 8'h05, 8'd64, 3'd1, 4'h0);
    add(0, 4'h0, 4'h2, 8'h01, 8'd67, 1, 4'h2, 1, 8'd1, 8'hFF, 8'd66, 3'd1, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd68, 1, 4'h0, 1, 8'd1, 8'h01, 8'd67, 3'd1, 4'h0);
    // source 1 opens without a header, repeats a header later, then async reset mid-packet
    add(0, 4'h2, 4'h0, 8'h00, 8'd70, 1, 4'h0, 0, 8'd1, 8'h01, 8'd67, 3'd1, 4'h0);
    add(0, 4'h2, 4'h2, 8'h00, 8'd71, 1, 4'h2, 0, 8'd1, 8'h01, 8'd67, 3'd1, 4'h0);
    add(0, 4'h2, 4'h2, 8'hFF, 8'd72, 1, 4'h2, 1, 8'd1, 8'h00, 8'd71, 3'd1, 4'h2);
    add(0, 4'h0, 4'h0, 8'h00, 8'd73, 1, 4'h2, 1, 8'd1, 8'hFF, 8'd72, 3'd1, 4'h2);
    add(1, 4'h0, 4'h0, 8'h00, 8'd74, 1, 4'h0, 0, 8'd0, 8'h00, 8'd0,  3'd0, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd75, 1, 4'h0, 0, 8'd0, 8'h00, 8'd0,  3'd0, 4'h0);
    add(0, 4'h2, 4'h0, 8'h00, 8'd76, 1, 4'h0, 0, 8'd0, 8'h00, 8'd0,  3'd0, 4'h0);
    add(0, 4'h2, 4'h2, 8'hFF, 8'd77, 1, 4'h2, 0, 8'd0, 8'h00, 8'd0,  3'd1, 4'h0);
    add(0, 4'h0, 4'h2, 8'h01, 8'd78, 1, 4'h2, 1, 8'd1, 8'hFF, 8'd77, 3'd1, 4'h0);
    add(0, 4'h0, 4'h0, 8'h00, 8'd79, 1, 4'h0, 1, 8'd1, 8'h01, 8'd78, 3'd1, 4'h0);

    drive(4'hF, 4'h0, 8'h00, 8'd0, 1'b1);
    #2 ARESETN = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      drive(4'hF, 4'hF, 8'hFF, 8'(c), 1'b1);
      #1;
      n_vec++;
      if ({pbs.S_PBS_RDY, pbs.M_PBS_WR, PROTO_ERR, GRANT_ID, pbs.M_PBS_DATA, pbs.M_PBS_CTRL} !== '0) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got rdy=%b wr=%b perr=%b gid=%0d data=%h ctrl=%h, want all zero",
                 c, pbs.S_PBS_RDY, pbs.M_PBS_WR, PROTO_ERR, GRANT_ID, pbs.M_PBS_DATA, pbs.M_PBS_CTRL);
      end
    end

    foreach (vq[i]) begin
      v = vq[i];
      @(negedge ACLK);
      ARESETN = !v.rst;
      drive(v.req, v.wr, v.ctrl, v.tag, v.mrdy);
      #1;
      act = {pbs.S_PBS_RDY, pbs.M_PBS_WR, pbs.M_PBS_DATA, pbs.M_PBS_CTRL, GRANT_ID, PROTO_ERR};
      exp = {v.e_rdy, v.e_wr, {v.e_src, 40'h0, v.e_ctrl, v.e_tag}, v.e_ctrl, v.e_gid,
             CHK ? v.e_perr : 4'h0};
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec %0d: got rdy=%b wr=%b data=%h ctrl=%h gid=%0d perr=%b; want rdy=%b wr=%b data=%h ctrl=%h gid=%0d perr=%b",
                 i, act[83:80], act[79], act[78:15], act[14:7], act[6:4], act[3:0],
                 exp[83:80], exp[79], exp[78:15], exp[14:7], exp[6:4], exp[3:0]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
